comparator_signed: RTL and testbench

COMPARATOR_SIGNED -- requirements
Module: comparator_signed

---
 rtl/comparator_unsigned.sv | 25 ++
 rtl/comparator_signed.sv | 101 ++++++++++
 tb/tb_comparator_signed.sv | 131 +++++++++++++
 3 files changed

// File: rtl/comparator_unsigned.sv
// comparator_unsigned
//   Purely combinational magnitude comparator for M-bit unsigned operands.
//   Exactly one of greater/equal/lesser is high for any operand pair.
// Ports:
//   a, b     : M-bit unsigned operands
//   greater  : a > b
//   equal    : a == b
//   lesser   : a < b
module comparator_unsigned #(
  parameter int M = 31
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         greater,
  output logic         equal,
  output logic         lesser
);

  always_comb begin
    equal   = (a == b);
    greater = (a > b);
    lesser  = ~equal & ~greater;
  end

endmodule

// File: rtl/comparator_signed.sv
// comparator_signed
//   Registered three-way comparison of two N-bit two's-complement operands.
//   Differing sign bits decide directly (the negative operand is lesser);
//   matching sign bits defer to an unsigned compare of the magnitude bits
//   N-2..0. No subtraction carry/overflow is involved in the decision.
//   One comparison per cycle, latency 1; flags hold while valid_i is low.
// Ports:
//   clk_i     : clock, rising edge
//   rst_n_i   : asynchronous active-low reset, clears all outputs
//   A_i, B_i  : N-bit signed operands, sampled when valid_i=1
//   valid_i   : operands valid on this edge
//   greater_o : registered signed A > B
//   equal_o   : registered A == B
//   lesser_o  : registered signed A < B
//   valid_o   : registered copy of valid_i
module comparator_signed #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  input  logic         valid_i,
  output logic         greater_o,
  output logic         equal_o,
  output logic         lesser_o,
  output logic         valid_o
);

  logic signed [N-1:0] a_p0;
  logic signed [N-1:0] b_p0;
  logic                vld_p0;
  logic                mag_gt_p0;
  logic                mag_eq_p0;
  logic                mag_lt_p0;
  logic                sign_a_p0;
  logic                sign_b_p0;
  logic                greater_p0;
  logic                equal_p0;
  logic                lesser_p0;

  logic                greater_p1;
  logic                equal_p1;
  logic                lesser_p1;
  logic                vld_p1;

  // ---- stage p0: combinational sign resolution on the live inputs ----
  assign a_p0      = A_i;
  assign b_p0      = B_i;
  assign vld_p0    = valid_i;
  assign sign_a_p0 = a_p0[N-1];
  assign sign_b_p0 = b_p0[N-1];

  comparator_unsigned #(
    .M (N-1)
  ) u_mag (
    .a       (a_p0[N-2:0]),
    .b       (b_p0[N-2:0]),
    .greater (mag_gt_p0),
    .equal   (mag_eq_p0),
    .lesser  (mag_lt_p0)
  );

  always_comb begin
    if (sign_a_p0 != sign_b_p0) begin
      // Whichever operand carries the sign bit is the smaller one.
      greater_p0 = sign_b_p0;
      equal_p0   = 1'b0;
      lesser_p0  = sign_a_p0;
    end else begin
      // Same sign: two's-complement ordering matches magnitude-bit ordering
      // for both positive and negative operands.
      greater_p0 = mag_gt_p0;
      equal_p0   = mag_eq_p0;
      lesser_p0  = mag_lt_p0;
    end
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1     <= 1'b0;
      greater_p1 <= 1'b0;
      equal_p1   <= 1'b0;
      lesser_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        greater_p1 <= greater_p0;
        equal_p1   <= equal_p0;
        lesser_p1  <= lesser_p0;
      end
    end
  end

  assign greater_o = greater_p1;
  assign equal_o   = equal_p1;
  assign lesser_o  = lesser_p1;
  assign valid_o   = vld_p1;

endmodule

// File: tb/tb_comparator_signed.sv
// tb_comparator_signed
//   Directed-vector bench for comparator_signed (N=32). Each check compares
//   the packed output word {valid_o, greater_o, equal_o, lesser_o} against a
//   hand-computed constant.
module tb_comparator_signed;

  localparam int N = 32;

  localparam logic [3:0] RES_GT = 4'b1100;
  localparam logic [3:0] RES_EQ = 4'b1010;
  localparam logic [3:0] RES_LT = 4'b1001;
  localparam logic [3:0] RES_0  = 4'b0000;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         valid;
  logic         greater;
  logic         equal;
  logic         lesser;
  logic         valid_out;

  int n_checks = 0;
  int n_pass   = 0;

  comparator_signed #(
    .N (N)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .A_i       (a),
    .B_i       (b),
    .valid_i   (valid),
    .greater_o (greater),
    .equal_o   (equal),
    .lesser_o  (lesser),
    .valid_o   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {valid_out, greater, equal, lesser};
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {v,g,e,l}=%b expected %b", tag, got, exp);
  endtask

  // Drive one operand pair away from the active edge, then sample 1 after it.
  task automatic cmp(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                     input logic [3:0] exp);
    @(negedge clk);
    a     = va;
    b     = vb;
    valid = 1'b1;
    @(posedge clk);
    #1;
    check(tag, outs(), exp);
  endtask

  initial begin
    rst_n = 1'b1;
    valid = 1'b0;
    a     = '0;
    b     = '0;
    #2 rst_n = 1'b0;
    #1 check("reset_state", outs(), RES_0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cmp("zero_eq",       32'h00000000, 32'h00000000, RES_EQ);
    cmp("one_gt_zero",   32'h00000001, 32'h00000000, RES_GT);
    cmp("pos_gt",        32'h0FEDCBA9, 32'h01234567, RES_GT);
    cmp("pos_lt",        32'h01234567, 32'h0FEDCBA9, RES_LT);
    cmp("pos_eq",        32'h0FEDCBA9, 32'h0FEDCBA9, RES_EQ);
    cmp("mixed_gt",      32'h00000098, 32'hFFFFFFD6, RES_GT);
    cmp("mixed_lt",      32'hFFFFFFD6, 32'h00000098, RES_LT);
    cmp("neg_lt",        32'hFFFFFF00, 32'hFFFFFFE5, RES_LT);
    cmp("neg_gt",        32'hFFFFFFE5, 32'hFFFFFF00, RES_GT);
    cmp("neg_eq",        32'hFFFFFFE5, 32'hFFFFFFE5, RES_EQ);
    cmp("minneg_lt_max", 32'h80000000, 32'h7FFFFFFF, RES_LT);
    cmp("max_gt_minneg", 32'h7FFFFFFF, 32'h80000000, RES_GT);
    cmp("minneg_lt_m1",  32'h80000000, 32'hFFFFFFFF, RES_LT);
    cmp("m1_lt_zero",    32'hFFFFFFFF, 32'h00000000, RES_LT);

    // valid_i low: flags keep the last lesser result, valid_o drops.
    @(negedge clk);
    valid = 1'b0;
    a     = 32'h00000005;
    b     = 32'h00000001;
    @(posedge clk);
    #1 check("hold_1", outs(), 4'b0001);
    @(negedge clk);
    @(posedge clk);
    #1 check("hold_2", outs(), 4'b0001);

    cmp("after_hold_gt", 32'h00000005, 32'h00000001, RES_GT);

    // Mid-stream reset: outputs clear without a clock edge.
    @(negedge clk);
    a     = 32'h00000003;
    b     = 32'h00000003;
    valid = 1'b1;
    @(posedge clk);
    #1 check("pre_reset_eq", outs(), RES_EQ);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), RES_0);
    // Edge during reset with valid_i high must be discarded.
    @(posedge clk);
    #1 check("reset_edge", outs(), RES_0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1 check("post_reset_idle", outs(), RES_0);

    cmp("post_reset_lt", 32'h80000000, 32'h00000001, RES_LT);

    @(negedge clk);
    valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
